// File: rtl/or16_collector.sv
// Sticky-bit collector: OR-accumulates a window of up to WIN input words and
// presents the result, word count and zero/all-ones flags over a valid/ready pair.
module or16_collector #(
  parameter int WIDTH = 16,
  parameter int WIN   = 4,
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [CNT_W-1:0] out_count_o,
  output logic             out_zero_o,
  output logic             out_ones_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [CNT_W-1:0] WIN_CNT  = CNT_W'(WIN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_zero_q, out_zero_d;
  logic             out_ones_q, out_ones_d;

  logic             accept;
  logic [CNT_W-1:0] cnt_inc;
  logic             done_d;

  // The input side is closed only while a result waits; this is what creates
  // the single bubble cycle after every result.
  assign in_ready_o = (state_q != S_DONE);
  assign accept     = in_valid_i && in_ready_o;
  assign cnt_inc    = cnt_q + CNT_ONE;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          acc_d   = in_data_i;
          cnt_d   = CNT_ONE;
          state_d = ((WIN == 1) || flush_i) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (accept) begin
          acc_d = acc_q | in_data_i;
          cnt_d = cnt_inc;
          if ((cnt_inc == WIN_CNT) || flush_i) begin
            state_d = S_DONE;
          end
        end else if (flush_i) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready_i) begin
          state_d = S_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Output registers are loaded from next-state values so the result appears
  // the cycle after the closing edge and stays frozen while DONE is held.
  always_comb begin
    done_d      = (state_d == S_DONE);
    out_valid_d = done_d;
    out_data_d  = done_d ? acc_d : '0;
    out_count_d = done_d ? cnt_d : '0;
    out_zero_d  = done_d && (acc_d == '0);
    out_ones_d  = done_d && (acc_d == ALL_ONES);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_zero_q  <= 1'b0;
      out_ones_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_zero_q  <= out_zero_d;
      out_ones_q  <= out_ones_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_count_o = out_count_q;
  assign out_zero_o  = out_zero_q;
  assign out_ones_o  = out_ones_q;

endmodule

// File: tb/tb_or16_collector.sv
// Testbench for or16_collector: directed scenarios plus randomized traffic,
// compared against a window-queue model of the collector.
module tb_or16_collector;

  localparam int WIDTH = 16;
  localparam int WIN   = 4;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             inValid = 1'b0;
  logic             inReady;
  logic [WIDTH-1:0] inData = '0;
  logic             flush = 1'b0;
  logic             outValid;
  logic             outReady = 1'b0;
  logic [WIDTH-1:0] outData;
  logic [CNT_W-1:0] outCount;
  logic             outZero;
  logic             outOnes;

  int checks = 0;
  int errors = 0;

  // Reference model: words of the open window, plus the pending result.
  logic [WIDTH-1:0] mWin[$];
  logic             mPending = 1'b0;
  logic [WIDTH-1:0] mData = '0;
  logic [CNT_W-1:0] mCount = '0;

  always #5 clk = ~clk;

  or16_collector #(.WIDTH(WIDTH), .WIN(WIN), .CNT_W(CNT_W)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .in_valid_i(inValid),
    .in_ready_o(inReady),
    .in_data_i(inData),
    .flush_i(flush),
    .out_valid_o(outValid),
    .out_ready_i(outReady),
    .out_data_o(outData),
    .out_count_o(outCount),
    .out_zero_o(outZero),
    .out_ones_o(outOnes)
  );

  function automatic logic [WIDTH-1:0] orOfWindow();
    logic [WIDTH-1:0] r = '0;
    foreach (mWin[i]) r = r | mWin[i];
    return r;
  endfunction

  task automatic modelStep();
    if (rst) begin
      mWin.delete();
      mPending = 1'b0;
      mData    = '0;
      mCount   = '0;
    end else if (mPending) begin
      if (outReady) mPending = 1'b0;
    end else begin
      if (inValid) mWin.push_back(inData);
      if (mWin.size() == WIN || (flush && mWin.size() > 0)) begin
        mData    = orOfWindow();
        mCount   = CNT_W'(mWin.size());
        mPending = 1'b1;
        mWin.delete();
      end
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then return at the falling edge.
  task automatic applyStimulus(input logic r, input logic v, input logic [WIDTH-1:0] d,
                               input logic f, input logic o);
    rst = r; inValid = v; inData = d; flush = f; outReady = o;
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic test_reset();
    applyStimulus(1, 1, 16'hABCD, 1, 0);
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", outValid); end
    checks++; if (outData !== 16'h0000) begin errors++; $display("[TB] FAIL reset_data: got %h want 0000", outData); end
    checks++; if (outCount !== 5'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d want 0", outCount); end
    checks++; if (outZero !== 1'b0 || outOnes !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got zero=%b ones=%b want 0 0", outZero, outOnes); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 1", inReady); end
  endtask

  task automatic test_full_window();
    logic [WIDTH-1:0] words[4] = '{16'h0001, 16'h0010, 16'h0100, 16'h1000};
    applyStimulus(1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, words[i], 0, 1);
      if (i < 3) begin
        checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL full_early_valid[%0d]: got %b want 0", i, outValid); end
      end
    end
    checks++; if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL full_valid: got %b want 1", outValid); end
    checks++; if (outData !== 16'h1111) begin errors++; $display("[TB] FAIL full_data: got %h want 1111", outData); end
    checks++; if (outCount !== 5'd4) begin errors++; $display("[TB] FAIL full_count: got %0d want 4", outCount); end
    checks++; if (outZero !== 1'b0 || outOnes !== 1'b0) begin errors++; $display("[TB] FAIL full_flags: got zero=%b ones=%b want 0 0", outZero, outOnes); end
    checks++; if (inReady !== 1'b0) begin errors++; $display("[TB] FAIL full_in_ready_done: got %b want 0", inReady); end
    applyStimulus(0, 0, 0, 0, 1);
    checks++; if (outValid !== 1'b0 || inReady !== 1'b1) begin errors++; $display("[TB] FAIL full_release: got valid=%b ready=%b want 0 1", outValid, inReady); end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] words[4] = '{16'h0001, 16'h0010, 16'h0100, 16'h1000};
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, words[i], 0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 16'hFFFF, 0, 0);
      checks++; if (outValid !== 1'b1 || outData !== 16'h1111 || inReady !== 1'b0) begin
        errors++; $display("[TB] FAIL bp_hold[%0d]: got valid=%b data=%h ready=%b want 1 1111 0", i, outValid, outData, inReady);
      end
    end
    applyStimulus(0, 1, 16'hFFFF, 0, 1);
    checks++; if (outValid !== 1'b0 || inReady !== 1'b1) begin errors++; $display("[TB] FAIL bp_release: got valid=%b ready=%b want 0 1", outValid, inReady); end
    applyStimulus(0, 1, 16'hFFFF, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 16'h0000, 0, 0);
      checks++; if (outValid !== (i == 2)) begin errors++; $display("[TB] FAIL bp_next_valid[%0d]: got %b want %b", i, outValid, (i == 2)); end
    end
    checks++; if (outData !== 16'hFFFF || outCount !== 5'd4 || outOnes !== 1'b1) begin
      errors++; $display("[TB] FAIL bp_next_result: got data=%h count=%0d ones=%b want ffff 4 1", outData, outCount, outOnes);
    end
    applyStimulus(0, 0, 0, 0, 1);
  endtask

  task automatic test_early_flush();
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 16'h00F0, 0, 0);
    applyStimulus(0, 0, 16'h7777, 1, 0);
    checks++; if (outValid !== 1'b1 || outData !== 16'h00F0 || outCount !== 5'd1) begin
      errors++; $display("[TB] FAIL flush_idle_word: got valid=%b data=%h count=%0d want 1 00f0 1", outValid, outData, outCount);
    end
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 1, 16'h00F0, 0, 0);
    applyStimulus(0, 1, 16'h0F00, 1, 0);
    checks++; if (outValid !== 1'b1 || outData !== 16'h0FF0 || outCount !== 5'd2) begin
      errors++; $display("[TB] FAIL flush_with_word: got valid=%b data=%h count=%0d want 1 0ff0 2", outValid, outData, outCount);
    end
    applyStimulus(0, 0, 0, 0, 1);
  endtask

  task automatic test_flags();
    logic [WIDTH-1:0] mix[4] = '{16'hFF00, 16'h00FF, 16'h0000, 16'h0000};
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL flush_in_idle: got valid=%b want 0", outValid); end
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 16'h0000, 0, 0);
    checks++; if (outValid !== 1'b1 || outZero !== 1'b1 || outOnes !== 1'b0 || outCount !== 5'd4) begin
      errors++; $display("[TB] FAIL flag_zero: got valid=%b zero=%b ones=%b count=%0d want 1 1 0 4", outValid, outZero, outOnes, outCount);
    end
    applyStimulus(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, mix[i], 0, 0);
    checks++; if (outData !== 16'hFFFF || outOnes !== 1'b1 || outZero !== 1'b0) begin
      errors++; $display("[TB] FAIL flag_ones: got data=%h ones=%b zero=%b want ffff 1 0", outData, outOnes, outZero);
    end
    applyStimulus(0, 0, 0, 0, 1);
  endtask

  task automatic test_reset_mid();
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 16'hF0F0, 0, 0);
    applyStimulus(0, 1, 16'h0F0E, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checks++; if (outValid !== 1'b0 || outCount !== 5'd0 || inReady !== 1'b1) begin
      errors++; $display("[TB] FAIL mid_reset: got valid=%b count=%0d ready=%b want 0 0 1", outValid, outCount, inReady);
    end
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 16'h0001, 0, 0);
    checks++; if (outValid !== 1'b1 || outData !== 16'h0001 || outCount !== 5'd4) begin
      errors++; $display("[TB] FAIL mid_fresh_window: got valid=%b data=%h count=%0d want 1 0001 4", outValid, outData, outCount);
    end
    applyStimulus(1, 0, 0, 0, 0);
    checks++; if (outValid !== 1'b0 || outData !== 16'h0000 || inReady !== 1'b1) begin
      errors++; $display("[TB] FAIL done_reset: got valid=%b data=%h ready=%b want 0 0000 1", outValid, outData, inReady);
    end
  endtask

  task automatic test_sparse();
    logic             vPat[7] = '{1, 0, 0, 1, 0, 1, 1};
    logic [WIDTH-1:0] words[4] = '{16'h0002, 16'h0004, 16'h0008, 16'h8000};
    int k = 0;
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      if (vPat[i]) begin
        applyStimulus(0, 1, words[k], 0, 0);
        k++;
      end else begin
        applyStimulus(0, 0, 16'hFFFF, 0, 0);
      end
      checks++; if (outValid !== (i == 6)) begin errors++; $display("[TB] FAIL sparse_valid[%0d]: got %b want %b", i, outValid, (i == 6)); end
    end
    checks++; if (outData !== 16'h800E || outCount !== 5'd4) begin
      errors++; $display("[TB] FAIL sparse_result: got data=%h count=%0d want 800e 4", outData, outCount);
    end
    applyStimulus(0, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] expData;
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 5))
        0:       d = 16'h0000;
        1:       d = 16'hFFFF;
        default: d = WIDTH'($urandom);
      endcase
      applyStimulus($urandom_range(0, 79) == 0, $urandom_range(0, 2) != 0, d,
                    $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1);
      expData = mPending ? mData : '0;
      checks++; if (outValid !== mPending) begin errors++; $display("[TB] FAIL rand_valid@%0d: got %b want %b", i, outValid, mPending); end
      checks++; if (inReady !== !mPending) begin errors++; $display("[TB] FAIL rand_in_ready@%0d: got %b want %b", i, inReady, !mPending); end
      checks++; if (outData !== expData) begin errors++; $display("[TB] FAIL rand_data@%0d: got %h want %h", i, outData, expData); end
      checks++; if (outCount !== (mPending ? mCount : 5'd0)) begin errors++; $display("[TB] FAIL rand_count@%0d: got %0d want %0d", i, outCount, mPending ? mCount : 5'd0); end
      checks++; if (outZero !== (mPending && expData == 16'h0000)) begin errors++; $display("[TB] FAIL rand_zero@%0d: got %b", i, outZero); end
      checks++; if (outOnes !== (mPending && expData == 16'hFFFF)) begin errors++; $display("[TB] FAIL rand_ones@%0d: got %b", i, outOnes); end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_full_window();
    test_backpressure();
    test_early_flush();
    test_flags();
    test_reset_mid();
    test_sparse();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/or16_collector.md
Name: or16_collector

Overview:
- Sequential stage directly downstream of the 16-bit bitwise OR gate.
- Accepts a stream of 16-bit words over a valid/ready handshake and OR-accumulates them across a window of WIN words, or fewer if flushed early.
- Presents the accumulated word, the word count and zero/all-ones flags through an output valid/ready handshake.
- Used as a sticky-bit collector, for example to gather status or fault bits, ahead of the register/ALU stages.

Parameters:
- WIDTH, 16, data width of input and accumulated word.
- WIN, 4, words per window; legal range 1..31.
- CNT_W, 5, width of word counter and out_count; must satisfy WIN <= 2^CNT_W - 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  word to OR into the accumulator.
- flush  input  1  close the current window early.
- out_valid  output  1  accumulated result available.
- out_ready  input  1  consumer takes the result this cycle.
- out_data  output  WIDTH  OR of all words accepted in the window.
- out_count  output  CNT_W  number of words accepted in the window.
- out_zero  output  1  out_data == 0.
- out_ones  output  1  out_data is all ones.

Behaviour:
- Reset: rst sampled high at a rising edge forces the following, regardless of in-flight state.
  - state = IDLE
  - acc = 0, cnt = 0
  - out_valid = 0, out_data = 0, out_count = 0, out_zero = 0, out_ones = 0
  - in_ready = 1 from the first cycle after reset
  - A partial window or an unconsumed result is discarded.
- Accept: a word is accepted when in_valid && in_ready at a rising edge.
- States:
  - IDLE: window empty; in_ready = 1; out_valid = 0.
  - ACCUM: 1..WIN-1 words held; in_ready = 1; out_valid = 0.
  - DONE: result held; in_ready = 0; out_valid = 1.
- IDLE transitions:
  - On accept: acc <= in_data, cnt <= 1.
  - Next state is DONE if WIN == 1 or flush = 1, otherwise ACCUM.
  - flush without accept is ignored; no empty windows are ever produced.
- ACCUM transitions:
  - On accept: acc <= acc | in_data, cnt <= cnt + 1. Go to DONE if cnt + 1 == WIN or flush = 1.
  - flush without accept: go to DONE with the current acc/cnt.
  - Simultaneous accept and flush: the word is included, then go to DONE.
- DONE:
  - out_data = acc, out_count = cnt.
  - out_zero = (acc == 0), out_ones = (acc == all ones).
  - All outputs are held stable while out_ready = 0.
  - On out_ready = 1: go to IDLE, acc <= 0, cnt <= 0.
  - No input bypass: in_ready = 0 in DONE, so one bubble cycle follows each result.
  - flush and in_data are ignored in DONE.
- Latency: out_valid rises on the clock edge that accepts the closing word or flush. The result is visible in the following cycle.
- Outputs are registered and driven from state/acc/cnt only, with no combinational path from inputs to outputs.
- in_ready depends only on state.
- cnt never exceeds WIN; out_count is always in 1..WIN when out_valid = 1.
- in_valid is permitted to drop between words; idle cycles do not advance cnt.
- The OR is bitwise over WIDTH bits with no carry or width change.

Test Plan:
- Reset then full window, WIN = 4:
  - Stimulus: words 0x0001, 0x0010, 0x0100, 0x1000 on consecutive cycles, out_ready = 1.
  - Required: out_valid = 1 for one cycle with out_data = 0x1111, out_count = 4, out_zero = 0, out_ones = 0; in_ready = 0 that cycle, then back to 1.
- Backpressure:
  - Stimulus: same window with out_ready = 0 for 5 cycles, in_valid held high with 0xFFFF.
  - Required: out_data stays 0x1111, in_ready = 0, and no 0xFFFF is accepted until one cycle after out_ready = 1. The next window then starts with 0xFFFF.
- Early flush:
  - Stimulus: 0x00F0 accepted, then a cycle with flush = 1 and in_valid = 0.
  - Required: out_data = 0x00F0, out_count = 1.
  - Stimulus: 0x0F00 with flush = 1 on the same cycle as the second word, after 0x00F0.
  - Required: out_data = 0x0FF0, out_count = 2.
- Flags and flush in IDLE:
  - Stimulus: flush = 1 in IDLE.
  - Required: no out_valid.
  - Stimulus: window 0x0000 ×4.
  - Required: out_zero = 1.
  - Stimulus: window 0xFF00, 0x00FF, 0x0000, 0x0000.
  - Required: out_data = 0xFFFF, out_ones = 1.
- Reset mid-operation:
  - Stimulus: rst = 1 after 2 words accepted.
  - Required: next cycle out_valid = 0, out_count = 0. A fresh 4-word window of 0x0001 yields 0x0001, count 4, with no earlier bits leaking in.
  - Stimulus: rst asserted while in DONE.
  - Required: the held result is dropped.
- Sparse input:
  - Stimulus: in_valid toggling 1,0,0,1,0,1,1 with data 0x0002, 0x0004, 0x0008, 0x8000.
  - Required: a single result 0x800E, count 4, emitted the cycle after the 4th accept.
